riscv_proc_ctrl_mem_arb: RTL and testbench

Control-side arbiter that shares the processor's single memory request port between the instruction-fetch (imem) and data (dmem) requesters. It limits the number of in-flight requests to a credit count and records which requester issued each in-flight request, so in-order memory responses are steered back to the right client. It sits between the fetch/LSU control logic and the memory interface. It drives only handshake and select signals; the datapath muxes address and data using `mem_req_sel`.

---
 rtl/riscv_proc_ctrl_mem_arb.sv | 109 ++++++++++
 tb/tb_riscv_proc_ctrl_mem_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_proc_ctrl_mem_arb.sv
// Shares one memory request port between fetch and data requesters, bounding in-flight requests
// with a credit count and steering in-order responses by a source-tag FIFO. Option: RISCV_MEM_ARB_RR_EN.
module riscv_proc_ctrl_mem_arb #(
    parameter int LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         imem_req_val,
    output logic                         imem_req_rdy,
    input  logic                         dmem_req_val,
    output logic                         dmem_req_rdy,
    output logic                         mem_req_val,
    input  logic                         mem_req_rdy,
    output logic                         mem_req_sel,
    input  logic                         mem_resp_val,
    output logic                         imem_resp_val,
    output logic                         dmem_resp_val,
    output logic [$clog2(LIMIT+1)-1:0]   outstanding,
    output logic                         idle,
    output logic                         err
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam int PW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LIMIT_C  = CW'(LIMIT);
    localparam logic [PW-1:0] PTR_LAST = PW'(LIMIT - 1);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [LIMIT-1:0] tags_q, tags_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic full, fire, rsp, sel, head_tag;

    assign full     = (count_q == LIMIT_C);
    assign idle     = (count_q == '0);
    assign head_tag = tags_q[head_q];

    // Grant; with no requester the last grant is held so the datapath mux stays put.
    always_comb begin
        sel = last_q;
        if (imem_req_val && dmem_req_val) begin
`ifdef RISCV_MEM_ARB_RR_EN
            sel = ~last_q;
`else
            sel = 1'b1;
`endif
        end else if (imem_req_val) begin
            sel = 1'b0;
        end else if (dmem_req_val) begin
            sel = 1'b1;
        end
    end

    assign mem_req_val   = (imem_req_val || dmem_req_val) && !full;
    assign imem_req_rdy  = mem_req_rdy && !full && !sel;
    assign dmem_req_rdy  = mem_req_rdy && !full && sel;
    assign mem_req_sel   = sel;
    assign fire          = mem_req_val && mem_req_rdy;
    assign rsp           = mem_resp_val && !idle;
    assign imem_resp_val = rsp && !head_tag;
    assign dmem_resp_val = rsp && head_tag;
    assign outstanding   = count_q;
    assign err           = err_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        tags_d  = tags_q;
        last_d  = last_q;
        err_d   = err_q | (mem_resp_val && idle);
        if (fire) begin
            tags_d[tail_q] = sel;
            tail_d         = (tail_q == PTR_LAST) ? '0 : tail_q + PW'(1);
            last_d         = sel;
        end
        if (rsp) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + PW'(1);
        end
        // The counter alone tracks occupancy; pointers never compare against each other.
        case ({fire, rsp})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            tags_q  <= '0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            tags_q  <= tags_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_riscv_proc_ctrl_mem_arb.sv
// Scoreboard bench: per-cycle reference model of credits/grant, tag queue checked by a response monitor.
module tb_riscv_proc_ctrl_mem_arb;

    localparam int LIMIT = 4;
    localparam int CW    = $clog2(LIMIT + 1);

    logic clk = 1'b0;
    logic reset;
    logic imem_req_val, dmem_req_val, mem_req_rdy, mem_resp_val;
    logic imem_req_rdy, dmem_req_rdy, mem_req_val, mem_req_sel;
    logic imem_resp_val, dmem_resp_val, idle, err;
    logic [CW-1:0] outstanding;

    int checks = 0;
    int errors = 0;

    // Reference model state (represents the DUT state after the next clock edge once updated).
    int   m_cnt  = 0;
    logic m_last = 1'b1;
    logic m_err  = 1'b0;
    logic tag_q[$];

    riscv_proc_ctrl_mem_arb #(.LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_val  (imem_req_val),
        .imem_req_rdy  (imem_req_rdy),
        .dmem_req_val  (dmem_req_val),
        .dmem_req_rdy  (dmem_req_rdy),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_sel   (mem_req_sel),
        .mem_resp_val  (mem_resp_val),
        .imem_resp_val (imem_resp_val),
        .dmem_resp_val (dmem_resp_val),
        .outstanding   (outstanding),
        .idle          (idle),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model and combinational checks at the falling edge; model state advances 1 time unit later.
    always @(negedge clk) begin
        logic m_full, esel, fire, rsp;
        m_full = (m_cnt == LIMIT);
        if (imem_req_val && dmem_req_val) begin
`ifdef RISCV_MEM_ARB_RR_EN
            esel = ~m_last;
`else
            esel = 1'b1;
`endif
        end else if (imem_req_val) esel = 1'b0;
        else if (dmem_req_val)     esel = 1'b1;
        else                       esel = m_last;
        fire = (imem_req_val || dmem_req_val) && !m_full && mem_req_rdy;
        rsp  = mem_resp_val && (m_cnt != 0);
        if (!reset) begin
            chk("mem_req_val", mem_req_val, (imem_req_val || dmem_req_val) && !m_full);
            chk("mem_req_sel", mem_req_sel, esel);
            chk("imem_req_rdy", imem_req_rdy, mem_req_rdy && !m_full && !esel);
            chk("dmem_req_rdy", dmem_req_rdy, mem_req_rdy && !m_full && esel);
            chk("outstanding", outstanding, m_cnt);
            chk("idle", idle, m_cnt == 0);
            chk("err", err, m_err);
            chk("resp_any", imem_resp_val || dmem_resp_val, rsp);
        end
        #1;
        if (reset) begin
            m_cnt  = 0;
            m_last = 1'b1;
            m_err  = 1'b0;
            tag_q.delete();
        end else begin
            if (fire) begin
                tag_q.push_back(esel);
                m_last = esel;
            end
            if (mem_resp_val && m_cnt == 0) m_err = 1'b1;
            m_cnt = m_cnt + (fire ? 1 : 0) - (rsp ? 1 : 0);
        end
    end

    // Response monitor: each routed response must match the oldest issued tag.
    always @(negedge clk) begin
        logic t;
        if (!reset && (imem_resp_val || dmem_resp_val)) begin
            chk("resp_onehot", imem_resp_val && dmem_resp_val, 1'b0);
            chk("resp_pending", tag_q.size() != 0, 1'b1);
            if (tag_q.size() != 0) begin
                t = tag_q.pop_front();
                chk("resp_route", dmem_resp_val, t);
            end
        end
    end

    task automatic cyc(input logic iv, input logic dv, input logic rr, input logic rv);
        imem_req_val = iv;
        dmem_req_val = dv;
        mem_req_rdy  = rr;
        mem_resp_val = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_cnt > 0; i++) cyc(0, 0, 1, 1);
        chk("drained", outstanding, 0);
    endtask

    initial begin
        reset = 1'b1;
        imem_req_val = 0; dmem_req_val = 0; mem_req_rdy = 0; mem_resp_val = 0;
        #1;
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);

        // spurious response while idle, err must stick
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 0);
        drain();
        do_reset();

        // tie-break with responses returned every cycle
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, m_cnt > 0);
        drain();

        // fill to limit, then full-release timing
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 1, 0);
        drain();

        // routing: imem, dmem, dmem then three responses
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // simultaneous fire and response at count 2, then mixed wrap traffic
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(i[0], ~i[0], 1, i % 3 != 0);
        drain();

        // randomized traffic, responses only when something is in flight
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                (m_cnt > 0) && ($urandom_range(0, 2) != 0));
        drain();

        // reset mid-operation discards in-flight tags
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
